complex_row_writer: RTL and testbench



---
 rtl/complex_row_writer.sv | 108 ++++++++++
 tb/tb_complex_row_writer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/complex_row_writer.sv
// rtl/complex_row_writer.sv - packs a serial complex sample stream into N-lane RAM rows, one frame per start
module complex_row_writer #(
    parameter int BIT_WIDTH  = 11,
    parameter int ADDR_WIDTH = 11,
    parameter int f          = 77,
    parameter int N          = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [ADDR_WIDTH-1:0]               base_addr,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [BIT_WIDTH-1:0]                in_r,
    input  logic [BIT_WIDTH-1:0]                in_i,
    input  logic                                in_last,
    output logic                                we,
    output logic [ADDR_WIDTH-1:0]               write_address,
    output logic [N-1:0][2*BIT_WIDTH-1:0]       wr_data,
    output logic                                busy,
    output logic                                done,
    output logic [ADDR_WIDTH:0]                 rows_written
);

    localparam int CW = 2 * BIT_WIDTH;
    localparam int LW = (N > 1) ? $clog2(N) : 1;
    localparam logic [ADDR_WIDTH:0] FRAME_LAST = (ADDR_WIDTH + 1)'(f * N - 1);

    typedef enum logic [1:0] {IDLE, FILL, FLUSH, DONE} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [LW-1:0]          lane_cnt;
    logic [N-1:0][CW-1:0]   row_buf;
    logic [N-1:0][CW-1:0]   row_out;
    logic [ADDR_WIDTH-1:0]  row_ptr;
    logic                   xfer;
    logic                   row_done;
    logic                   frame_end;

    assign xfer      = in_valid && in_ready;
    assign row_done  = xfer && ((lane_cnt == LW'(N - 1)) || in_last);
    assign frame_end = row_done && (in_last || (rows_written == FRAME_LAST));
    assign busy      = (state == FILL) || (state == FLUSH);
    assign done      = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FILL;
            FILL:    if (frame_end) state_nxt = FLUSH;
            FLUSH:   state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Completed row: buffered lanes, the completing sample, zeros above it.
    always_comb begin
        row_out = '0;
        for (int j = 0; j < N; j++) begin
            if (LW'(j) < lane_cnt) begin
                row_out[j] = row_buf[j];
            end else if (LW'(j) == lane_cnt) begin
                row_out[j] = {in_r, in_i};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready      <= 1'b0;
            we            <= 1'b0;
            write_address <= '0;
            wr_data       <= '0;
            row_buf       <= '0;
            lane_cnt      <= '0;
            row_ptr       <= '0;
            rows_written  <= '0;
        end else begin
            in_ready <= (state_nxt == FILL);
            we       <= row_done;
            if (state == IDLE && start) begin
                row_ptr      <= base_addr;
                lane_cnt     <= '0;
                rows_written <= '0;
            end
            if (xfer) begin
                row_buf[lane_cnt] <= {in_r, in_i};
                lane_cnt          <= row_done ? '0 : lane_cnt + 1'b1;
            end
            if (row_done) begin
                wr_data       <= row_out;
                write_address <= row_ptr;
                row_ptr       <= row_ptr + 1'b1;
                rows_written  <= rows_written + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_complex_row_writer.sv
// tb/tb_complex_row_writer.sv - directed bench with a sample-queue reference model for complex_row_writer
module tb_complex_row_writer;

    localparam int BW = 11;
    localparam int AW = 11;
    localparam int F  = 77;
    localparam int N  = 16;

    typedef logic [N-1:0][2*BW-1:0] row_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] in_r = '0;
    logic [BW-1:0] in_i = '0;
    logic          in_last = 1'b0;
    logic          we;
    logic [AW-1:0] write_address;
    row_t          wr_data;
    logic          busy;
    logic          done;
    logic [AW:0]   rows_written;

    complex_row_writer #(.BIT_WIDTH(BW), .ADDR_WIDTH(AW), .f(F), .N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_i(in_i),
        .in_last(in_last), .we(we), .write_address(write_address),
        .wr_data(wr_data), .busy(busy), .done(done), .rows_written(rows_written)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input row_t act, input row_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: frame phase plus a queue of the samples of the row being built.
    int                  phase = 0;
    int                  m_rows = 0;
    logic [AW-1:0]       ptr = '0;
    logic [2*BW-1:0]     row_q[$];
    logic                m_ready = 0, m_we = 0, m_busy = 0, m_done = 0;
    logic [AW-1:0]       m_addr = '0;
    row_t                m_data = '0;

    always @(posedge clk) begin
        if (rst) begin
            phase = 0; m_rows = 0; ptr = '0; row_q.delete();
            m_ready = 0; m_we = 0; m_busy = 0; m_done = 0; m_addr = '0; m_data = '0;
        end else begin
            m_we = 0;
            case (phase)
                0: if (start) begin
                    ptr = base_addr; m_rows = 0; row_q.delete(); phase = 1;
                end
                1: if (in_valid && m_ready) begin
                    row_q.push_back({in_r, in_i});
                    if (row_q.size() == N || in_last) begin
                        m_we = 1; m_addr = ptr; m_data = '0;
                        foreach (row_q[i]) m_data[i] = row_q[i];
                        ptr = ptr + 1'b1; m_rows++; row_q.delete();
                        if (in_last || m_rows == F * N) phase = 2;
                    end
                end
                2: phase = 3;
                default: phase = 0;
            endcase
            m_ready = (phase == 1);
            m_busy  = (phase == 1) || (phase == 2);
            m_done  = (phase == 3);
        end
    end

    row_t          ram [0:(1<<AW)-1];
    row_t          ram_ref [0:(1<<AW)-1];
    int            wr_cnt = 0;
    int            done_cnt = 0;
    logic [AW-1:0] first_addr = '0;
    logic [AW-1:0] last_addr = '0;

    always @(negedge clk) begin
        check("in_ready", row_t'(in_ready), row_t'(m_ready));
        check("we", row_t'(we), row_t'(m_we));
        check("busy", row_t'(busy), row_t'(m_busy));
        check("done", row_t'(done), row_t'(m_done));
        if (we) begin
            check("write_address", row_t'(write_address), row_t'(m_addr));
            check("wr_data", wr_data, m_data);
            check("rows_written", row_t'(rows_written), row_t'(m_rows));
            ram[write_address] = wr_data;
            if (wr_cnt == 0) first_addr = write_address;
            last_addr = write_address;
            wr_cnt++;
        end
        if (done) begin
            check("rows_written_done", row_t'(rows_written), row_t'(m_rows));
            done_cnt++;
        end
    end

    task automatic begin_frame(input logic [AW-1:0] base);
        base_addr = base; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; wr_cnt = 0; done_cnt = 0;
    endtask

    task automatic send(input int n, input int last_idx, input int gap, input int start_at);
        int k = 0;
        int cyc = 0;
        logic rdy;
        while (k < n && cyc < 4 * n + 100) begin
            in_valid = ($urandom_range(99) >= gap);
            in_r     = BW'(k);
            in_i     = BW'(-k);
            in_last  = (k == last_idx);
            start    = (k == start_at);
            rdy      = in_ready;
            @(posedge clk); #1;
            if (in_valid && rdy) k++;
            cyc++;
        end
        in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
        check("send_complete", row_t'(k), row_t'(n));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int diff;
        row_t r;
        for (int a = 0; a < (1 << AW); a++) begin ram[a] = '0; ram_ref[a] = '0; end
        #1;
        do_reset();
        check("reset_in_ready", row_t'(in_ready), '0);
        check("reset_we", row_t'(we), '0);
        check("reset_rows", row_t'(rows_written), '0);
        check("reset_wr_data", wr_data, '0);
        check("reset_addr", row_t'(write_address), '0);

        // Full frame, continuous valid
        begin_frame(11'd0);
        send(F * N * N, -1, 0, -1);
        repeat (4) @(posedge clk); #1;
        check("full_wr_cnt", row_t'(wr_cnt), row_t'(1232));
        check("full_rows", row_t'(rows_written), row_t'(1232));
        check("full_first", row_t'(first_addr), row_t'(0));
        check("full_last", row_t'(last_addr), row_t'(1231));
        check("full_done_cnt", row_t'(done_cnt), row_t'(1));
        r = ram[0];
        check("row0_lane3", row_t'(r[3]), row_t'({11'd3, 11'h7FD}));
        for (int a = 0; a < (1 << AW); a++) begin ram_ref[a] = ram[a]; ram[a] = '0; end

        // Same frame with ~30% idle gaps must land identically
        do_reset();
        begin_frame(11'd0);
        send(F * N * N, -1, 30, -1);
        repeat (4) @(posedge clk); #1;
        diff = 0;
        for (int a = 0; a < 1232; a++) if (ram[a] !== ram_ref[a]) diff++;
        check("gap_ram_diff", row_t'(diff), '0);
        check("gap_wr_cnt", row_t'(wr_cnt), row_t'(1232));

        // Address wrap from 2040
        begin_frame(11'd2040);
        send(160, 159, 0, -1);
        repeat (4) @(posedge clk); #1;
        check("wrap_first", row_t'(first_addr), row_t'(2040));
        check("wrap_last", row_t'(last_addr), row_t'(1));
        check("wrap_wr_cnt", row_t'(wr_cnt), row_t'(10));

        // in_last on sample 5 of row 2
        begin_frame(11'd100);
        send(37, 36, 0, -1);
        repeat (4) @(posedge clk); #1;
        r = ram[102];
        check("last_rows", row_t'(rows_written), row_t'(3));
        check("last_lane4", row_t'(r[4]), row_t'({11'd36, 11'd2012}));
        check("last_lane5", row_t'(r[5]), '0);
        check("last_lane15", row_t'(r[15]), '0);
        check("last_done_cnt", row_t'(done_cnt), row_t'(1));
        check("last_in_ready", row_t'(in_ready), '0);

        // Reset in the middle of row 7
        begin_frame(11'd300);
        send(117, -1, 0, -1);
        check("midrst_wr_cnt", row_t'(wr_cnt), row_t'(7));
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_we", row_t'(we), '0);
        check("midrst_in_ready", row_t'(in_ready), '0);
        check("midrst_busy", row_t'(busy), '0);
        rst = 1'b0;
        begin_frame(11'd500);
        send(48, 47, 0, -1);
        repeat (4) @(posedge clk); #1;
        check("restart_first", row_t'(first_addr), row_t'(500));
        check("restart_rows", row_t'(rows_written), row_t'(3));

        // start during FILL and in the DONE cycle is ignored
        begin_frame(11'd700);
        send(64, 63, 0, 20);
        @(posedge clk); #1;
        check("done_cycle", row_t'(done), row_t'(1));
        start = 1'b1; base_addr = 11'd900;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk); #1;
        check("ign_busy", row_t'(busy), '0);
        check("ign_rows", row_t'(rows_written), row_t'(4));
        check("ign_wr_cnt", row_t'(wr_cnt), row_t'(4));
        check("ign_first", row_t'(first_addr), row_t'(700));
        check("ign_done_cnt", row_t'(done_cnt), row_t'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
